// File: rtl/bc_pkg.sv
// Shared types for the basic-computer datapath: control word, bus and ALU
// selector encodings, memory access FSM states and default widths.
package bc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        BUS_AR  = 3'd0,
        BUS_PC  = 3'd1,
        BUS_DR  = 3'd2,
        BUS_AC  = 3'd3,
        BUS_IR  = 3'd4,
        BUS_TR  = 3'd5,
        BUS_MBR = 3'd6,
        BUS_WRD = 3'd7
    } bus_sel_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_ADD = 3'd1,
        ALU_DR  = 3'd2,
        ALU_COM = 3'd3,
        ALU_SHR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_INP = 3'd6,
        ALU_AC  = 3'd7
    } alu_op_e;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic ld_ar;
        logic inr_ar;
        logic clr_ar;
        logic ld_pc;
        logic inr_pc;
        logic clr_pc;
        logic ld_dr;
        logic inr_dr;
        logic clr_dr;
        logic ld_ac;
        logic inr_ac;
        logic clr_ac;
        logic ld_tr;
        logic inr_tr;
        logic clr_tr;
        logic ld_ir;
        logic ld_e;
        logic cmp_e;
        logic clr_e;
        logic mem_rd;
        logic mem_wr;
    } ctrl_t;

endpackage

// File: rtl/bc_reg.sv
// Generic datapath register with clear > load > increment priority and
// asynchronous active-low reset. Increment wraps modulo 2^WIDTH.
module bc_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             inr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    // Next value from the clr/ld/inr priority chain.
    always_comb begin
        val_d = val_q;
        if (clr)
            val_d = '0;
        else if (ld)
            val_d = d;
        else if (inr)
            val_d = val_q + WIDTH'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            val_q <= '0;
        else
            val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/bc_datapath_gen.sv
// Basic-computer datapath: AR, PC, DR, AC, IR, TR, E, common bus, ALU and a
// request/acknowledge memory port. Register transfers stall while a memory
// access is outstanding.
module bc_datapath_gen
    import bc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        bus_sel,
    input  ctrl_t             ctrl,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] wrd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] ar_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] ac_out,
    output logic [DATA_W-1:0] dr_out,
    output logic [DATA_W-1:0] tr_out,
    output logic              e_out,
    output logic              ac_zero,
    output logic              ac_neg
);

    mem_state_e        state_q;
    ctrl_t             ctrl_eff;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    logic              alu_e;
    logic              e_q;
    logic              e_d;
    logic [DATA_W-1:0] mbr_q;
    logic              err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [ADDR_W-1:0] ar_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] dr_q;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] tr_q;

    // The sequencer's control word is squashed to all-zero while an access is pending.
    always_comb begin
        ctrl_eff = ctrl;
        if (state_q == MEM_ACCESS)
            ctrl_eff = '0;
    end

    // Common bus source select; address registers are zero-extended.
    always_comb begin
        bus = '0;
        case (bus_sel_e'(bus_sel))
            BUS_AR:  bus = DATA_W'(ar_q);
            BUS_PC:  bus = DATA_W'(pc_q);
            BUS_DR:  bus = dr_q;
            BUS_AC:  bus = ac_q;
            BUS_IR:  bus = ir_q;
            BUS_TR:  bus = tr_q;
            BUS_MBR: bus = mbr_q;
            BUS_WRD: bus = wrd;
            default: bus = '0;
        endcase
    end

    // ALU result and its E output; shifts rotate through E, ADD produces the carry.
    always_comb begin
        alu_res = ac_q;
        alu_e   = e_q;
        case (alu_op_e'(alu_op))
            ALU_AND: alu_res = ac_q & dr_q;
            ALU_ADD: {alu_e, alu_res} = {1'b0, ac_q} + {1'b0, dr_q};
            ALU_DR:  alu_res = dr_q;
            ALU_COM: alu_res = ~ac_q;
            ALU_SHR: begin
                alu_res = {e_q, ac_q[DATA_W-1:1]};
                alu_e   = ac_q[0];
            end
            ALU_SHL: begin
                alu_res = {ac_q[DATA_W-2:0], e_q};
                alu_e   = ac_q[DATA_W-1];
            end
            ALU_INP: alu_res = DATA_W'(bus[7:0]);
            ALU_AC:  alu_res = ac_q;
            default: alu_res = ac_q;
        endcase
    end

    bc_reg #(.WIDTH(ADDR_W)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .clr(ctrl_eff.clr_ar), .ld(ctrl_eff.ld_ar), .inr(ctrl_eff.inr_ar),
        .d(bus[ADDR_W-1:0]), .q(ar_q)
    );

    bc_reg #(.WIDTH(ADDR_W)) u_pc (
        .clk(clk), .rst_n(rst_n),
        .clr(ctrl_eff.clr_pc), .ld(ctrl_eff.ld_pc), .inr(ctrl_eff.inr_pc),
        .d(bus[ADDR_W-1:0]), .q(pc_q)
    );

    bc_reg #(.WIDTH(DATA_W)) u_dr (
        .clk(clk), .rst_n(rst_n),
        .clr(ctrl_eff.clr_dr), .ld(ctrl_eff.ld_dr), .inr(ctrl_eff.inr_dr),
        .d(bus), .q(dr_q)
    );

    bc_reg #(.WIDTH(DATA_W)) u_ac (
        .clk(clk), .rst_n(rst_n),
        .clr(ctrl_eff.clr_ac), .ld(ctrl_eff.ld_ac), .inr(ctrl_eff.inr_ac),
        .d(alu_res), .q(ac_q)
    );

    bc_reg #(.WIDTH(DATA_W)) u_ir (
        .clk(clk), .rst_n(rst_n),
        .clr(1'b0), .ld(ctrl_eff.ld_ir), .inr(1'b0),
        .d(bus), .q(ir_q)
    );

    bc_reg #(.WIDTH(DATA_W)) u_tr (
        .clk(clk), .rst_n(rst_n),
        .clr(ctrl_eff.clr_tr), .ld(ctrl_eff.ld_tr), .inr(ctrl_eff.inr_tr),
        .d(bus), .q(tr_q)
    );

    // E flag next value: clear > load from ALU > complement.
    always_comb begin
        e_d = e_q;
        if (ctrl_eff.clr_e)
            e_d = 1'b0;
        else if (ctrl_eff.ld_e)
            e_d = alu_e;
        else if (ctrl_eff.cmp_e)
            e_d = ~e_q;
    end

    // E flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e_q <= 1'b0;
        else
            e_q <= e_d;
    end

    // Memory access FSM; address, direction and write data are frozen on entry to ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MEM_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mbr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            // Simultaneous read and write resolves to a write and is flagged.
            if (ctrl_eff.mem_rd && ctrl_eff.mem_wr)
                err_q <= 1'b1;
            case (state_q)
                MEM_IDLE: begin
                    if (ctrl_eff.mem_rd || ctrl_eff.mem_wr) begin
                        state_q    <= MEM_ACCESS;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ar_q;
                        mem_we_q   <= ctrl_eff.mem_wr;
                        if (ctrl_eff.mem_wr)
                            mem_wdata_q <= bus;
                    end
                end
                MEM_ACCESS: begin
                    if (mem_ack) begin
                        state_q   <= MEM_IDLE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q)
                            mbr_q <= mem_rdata;
                    end
                end
                default: begin
                    state_q   <= MEM_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q == MEM_ACCESS);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign pc_out    = pc_q;
    assign ar_out    = ar_q;
    assign ir_out    = ir_q;
    assign ac_out    = ac_q;
    assign dr_out    = dr_q;
    assign tr_out    = tr_q;
    assign e_out     = e_q;
    assign ac_zero   = (ac_q == '0);
    assign ac_neg    = ac_q[DATA_W-1];

endmodule

// File: tb/tb_bc_datapath_gen.sv
// Scoreboard bench for bc_datapath_gen: the driver queues expected output
// values tagged with the cycle they must appear in; the monitor compares them
// on the falling edge of that cycle.
module tb_bc_datapath_gen;
    import bc_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;

    localparam int S_PC = 0, S_AR = 1, S_AC = 2, S_DR = 3, S_E = 4, S_ZERO = 5,
                   S_BUSY = 6, S_REQ = 7, S_ADDR = 8, S_WE = 9, S_WDATA = 10,
                   S_ERR = 11, S_NEG = 12, S_IR = 13, S_TR = 14;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [2:0]    bus_sel;
    ctrl_t         ctrl;
    logic [2:0]    alu_op;
    logic [DW-1:0] wrd;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          err;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] ar_out;
    logic [DW-1:0] ir_out;
    logic [DW-1:0] ac_out;
    logic [DW-1:0] dr_out;
    logic [DW-1:0] tr_out;
    logic          e_out;
    logic          ac_zero;
    logic          ac_neg;

    typedef struct {
        int          cyc;
        int          sig;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   flush  = 1'b0;

    bc_datapath_gen #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .ctrl(ctrl), .alu_op(alu_op),
        .wrd(wrd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .err(err), .pc_out(pc_out), .ar_out(ar_out), .ir_out(ir_out),
        .ac_out(ac_out), .dr_out(dr_out), .tr_out(tr_out), .e_out(e_out),
        .ac_zero(ac_zero), .ac_neg(ac_neg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sig);
        case (sig)
            S_PC:    return 32'(pc_out);
            S_AR:    return 32'(ar_out);
            S_AC:    return 32'(ac_out);
            S_DR:    return 32'(dr_out);
            S_E:     return 32'(e_out);
            S_ZERO:  return 32'(ac_zero);
            S_BUSY:  return 32'(busy);
            S_REQ:   return 32'(mem_req);
            S_ADDR:  return 32'(mem_addr);
            S_WE:    return 32'(mem_we);
            S_WDATA: return 32'(mem_wdata);
            S_ERR:   return 32'(err);
            S_NEG:   return 32'(ac_neg);
            S_IR:    return 32'(ir_out);
            S_TR:    return 32'(tr_out);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle; on flush, report leftovers.
    always @(negedge clk) begin
        logic [31:0] a;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                a = actual(sb[i].sig);
                checks++;
                if (a !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, cyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (flush) begin
            while (sb.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL %s never checked (due cyc=%0d)", sb[0].name, sb[0].cyc);
                sb.delete(0);
            end
        end
    end

    task automatic expect_now(int sig, string name, logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl    = '0;
        alu_op  = 3'd0;
        bus_sel = 3'd0;
        wrd     = '0;
    endtask

    initial begin
        idle();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1 rst_n = 1'b0;
        step();
        step();
        expect_now(S_PC, "rst_pc", 0);
        expect_now(S_AR, "rst_ar", 0);
        expect_now(S_AC, "rst_ac", 0);
        expect_now(S_E, "rst_e", 0);
        expect_now(S_BUSY, "rst_busy", 0);
        expect_now(S_REQ, "rst_req", 0);
        expect_now(S_ERR, "rst_err", 0);
        expect_now(S_WE, "rst_we", 0);
        expect_now(S_ADDR, "rst_addr", 0);
        expect_now(S_WDATA, "rst_wdata", 0);
        rst_n = 1'b1;

        // PC increments three times.
        ctrl.inr_pc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_now(S_PC, "pc_inr", 32'(k));
        end
        idle();

        // AR wraps from 0xFFF to 0.
        bus_sel = 3'd7; wrd = 16'h0FFF; ctrl.ld_ar = 1'b1;
        step(); expect_now(S_AR, "ar_ld", 32'h0FFF);
        idle(); ctrl.inr_ar = 1'b1;
        step(); expect_now(S_AR, "ar_wrap", 32'h000);
        idle();

        // AC = 0xFFFF via clear then complement; DR = 1; ADD carries into E.
        ctrl.clr_ac = 1'b1;
        step(); expect_now(S_AC, "ac_clr", 0);
        idle(); alu_op = 3'd3; ctrl.ld_ac = 1'b1;
        step(); expect_now(S_AC, "ac_com", 32'hFFFF); expect_now(S_NEG, "ac_neg_com", 1);
        idle(); bus_sel = 3'd7; wrd = 16'h0001; ctrl.ld_dr = 1'b1;
        step(); expect_now(S_DR, "dr_ld", 1);
        idle(); alu_op = 3'd1; ctrl.ld_ac = 1'b1; ctrl.ld_e = 1'b1;
        step();
        expect_now(S_AC, "add_ac", 0); expect_now(S_E, "add_e", 1); expect_now(S_ZERO, "add_zero", 1);
        idle(); alu_op = 3'd4; ctrl.ld_ac = 1'b1; ctrl.ld_e = 1'b1;
        step();
        expect_now(S_AC, "shr_ac", 32'h8000); expect_now(S_E, "shr_e", 0); expect_now(S_NEG, "shr_neg", 1);
        idle(); alu_op = 3'd5; ctrl.ld_ac = 1'b1; ctrl.ld_e = 1'b1;
        step(); expect_now(S_AC, "shl_ac", 0); expect_now(S_E, "shl_e", 1);
        idle(); ctrl.cmp_e = 1'b1;
        step(); expect_now(S_E, "cmp_e", 0);
        ctrl.clr_e = 1'b1;
        step(); expect_now(S_E, "clr_over_cmp", 0);
        idle();

        // Read at 0x123, ack in the third busy cycle, PC inr during busy ignored.
        bus_sel = 3'd7; wrd = 16'h0123; ctrl.ld_ar = 1'b1;
        step(); expect_now(S_AR, "ar_123", 32'h123);
        idle(); ctrl.mem_rd = 1'b1;
        step();
        expect_now(S_BUSY, "rd_busy1", 1); expect_now(S_REQ, "rd_req1", 1);
        expect_now(S_ADDR, "rd_addr1", 32'h123); expect_now(S_WE, "rd_we", 0);
        idle(); ctrl.inr_pc = 1'b1;
        step();
        expect_now(S_BUSY, "rd_busy2", 1); expect_now(S_ADDR, "rd_addr2", 32'h123);
        idle();
        step();
        expect_now(S_BUSY, "rd_busy3", 1); expect_now(S_ADDR, "rd_addr3", 32'h123);
        expect_now(S_PC, "pc_stalled", 3);
        mem_rdata = 16'hBEEF; mem_ack = 1'b1;
        step();
        expect_now(S_BUSY, "rd_done", 0); expect_now(S_REQ, "rd_req_off", 0);
        mem_ack = 1'b0; mem_rdata = '0;
        bus_sel = 3'd6; ctrl.ld_dr = 1'b1;
        step(); expect_now(S_DR, "mbr_to_dr", 32'hBEEF);
        idle();

        // Write AC = 0x5A5A; data held while the bus changes.
        bus_sel = 3'd7; wrd = 16'h5A5A; ctrl.ld_dr = 1'b1;
        step();
        idle(); alu_op = 3'd2; ctrl.ld_ac = 1'b1;
        step(); expect_now(S_AC, "ac_5a5a", 32'h5A5A);
        idle(); bus_sel = 3'd3; ctrl.mem_wr = 1'b1;
        step();
        expect_now(S_WE, "wr_we", 1); expect_now(S_WDATA, "wr_wdata1", 32'h5A5A);
        expect_now(S_REQ, "wr_req", 1); expect_now(S_ADDR, "wr_addr", 32'h123);
        expect_now(S_ERR, "wr_no_err", 0);
        idle(); bus_sel = 3'd7; wrd = 16'hFFFF;
        step(); expect_now(S_WDATA, "wr_wdata2", 32'h5A5A); expect_now(S_WE, "wr_we2", 1);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step(); expect_now(S_BUSY, "wr_done", 0);
        step(); expect_now(S_BUSY, "ack_idle_busy", 0); expect_now(S_REQ, "ack_idle_req", 0);
        mem_ack = 1'b0;

        // Read and write together: write wins, err sticks, MBR untouched.
        bus_sel = 3'd7; wrd = 16'h1234; ctrl.mem_rd = 1'b1; ctrl.mem_wr = 1'b1;
        step();
        expect_now(S_WE, "rw_we", 1); expect_now(S_WDATA, "rw_wdata", 32'h1234);
        expect_now(S_ERR, "rw_err", 1); expect_now(S_BUSY, "rw_busy", 1);
        idle(); mem_ack = 1'b1;
        step(); expect_now(S_BUSY, "rw_done", 0); expect_now(S_ERR, "err_sticky1", 1);
        mem_ack = 1'b0; mem_rdata = '0;
        bus_sel = 3'd6; ctrl.ld_dr = 1'b1;
        step(); expect_now(S_DR, "mbr_kept", 32'hBEEF); expect_now(S_ERR, "err_sticky2", 1);
        idle();

        // AC priority: clr > ld > inr.
        bus_sel = 3'd7; wrd = 16'h0007; ctrl.ld_dr = 1'b1;
        step();
        idle(); alu_op = 3'd2; ctrl.ld_ac = 1'b1;
        step(); expect_now(S_AC, "ac_7", 7);
        ctrl.clr_ac = 1'b1; ctrl.inr_ac = 1'b1;
        step(); expect_now(S_AC, "ac_clr_prio", 0);
        ctrl.clr_ac = 1'b0;
        step(); expect_now(S_AC, "ac_ld_prio", 7);
        idle(); bus_sel = 3'd3; ctrl.ld_tr = 1'b1; ctrl.ld_ir = 1'b1;
        step(); expect_now(S_TR, "tr_ld", 7); expect_now(S_IR, "ir_ld", 7);
        idle(); ctrl.inr_tr = 1'b1;
        step(); expect_now(S_TR, "tr_inr", 8);
        idle();

        // Asynchronous reset in the middle of an access.
        ctrl.mem_rd = 1'b1;
        step(); expect_now(S_BUSY, "rst_acc_busy", 1); expect_now(S_REQ, "rst_acc_req", 1);
        idle();
        step();
        rst_n = 1'b0;
        expect_now(S_REQ, "arst_req", 0); expect_now(S_BUSY, "arst_busy", 0);
        expect_now(S_ERR, "arst_err", 0); expect_now(S_PC, "arst_pc", 0);
        expect_now(S_AR, "arst_ar", 0); expect_now(S_AC, "arst_ac", 0);
        expect_now(S_DR, "arst_dr", 0); expect_now(S_TR, "arst_tr", 0);
        expect_now(S_IR, "arst_ir", 0); expect_now(S_ADDR, "arst_addr", 0);
        expect_now(S_WDATA, "arst_wdata", 0); expect_now(S_E, "arst_e", 0);
        step();
        rst_n = 1'b1;
        step(); expect_now(S_BUSY, "post_rst_busy", 0);

        step();
        flush = 1'b1;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bc_datapath_gen.md
# bc_datapath_gen

Parametrised basic-computer datapath: AR, PC, DR, AC, IR, TR, E flag, 8-source common bus and ALU, with configurable data and address widths. Unlike a single-cycle datapath with an internal memory, it reaches memory through a request/acknowledge port with a multi-cycle access FSM. It stalls register transfers while an access is outstanding. It sits under the control sequencer, which drives one control word per cycle and observes `busy`.

## Interface
- `DATA_W`, 16: width of DR, AC, IR, TR, bus and memory data.
- `ADDR_W`, 12: width of AR, PC and the memory address (must be ≤ `DATA_W`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_sel`  in  3  bus source:
  - 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR: AR and PC are zero-extended to `DATA_W`.
  - 6 MBR (last memory read data).
  - 7 `wrd`.
- `ctrl`  in  `ctrl_t`  packed control word:
  - Per register: `ld`/`inr`/`clr` for AR, PC, DR, AC and TR; `ld_ir`.
  - E flag: `ld_e`, `cmp_e`, `clr_e`.
  - Memory: `mem_rd`, `mem_wr`.
- `alu_op`  in  3  ALU operation:
  - 0 AND, 1 ADD, 2 pass DR, 3 COM AC.
  - 4 SHR, 5 SHL, 6 pass bus[7:0] zero-extended, 7 pass AC.
- `wrd`  in  `DATA_W`  external word (bus source 7).
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  1 = write access.
- `mem_addr`  out  `ADDR_W`  access address.
- `mem_wdata`  out  `DATA_W`  write data.
- `mem_rdata`  in  `DATA_W`  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  access complete.
- `busy`  out  1  access outstanding; `ctrl` is ignored while high.
- `err`  out  1  sticky illegal-control flag.
- `pc_out`, `ar_out`  out  `ADDR_W`  register views.
- `ir_out`, `ac_out`, `dr_out`, `tr_out`  out  `DATA_W`  register views.
- `e_out`  out  1  E flag.
- `ac_zero`, `ac_neg`  out  1  AC == 0; AC MSB.

## Operation
- Register update priority per register: `clr` > `ld` > `inr`.
  - Increment wraps modulo 2^width.
  - AR/PC load from bus[`ADDR_W`-1:0].
  - DR, IR and TR load from the bus.
  - AC loads from the ALU result.
- ALU operations:
  - ADD produces a `DATA_W`+1 sum; the carry-out is the ALU E output.
  - SHR result is {E, AC[W-1:1]}, E output AC[0].
  - SHL result is {AC[W-2:0], E}, E output AC[W-1].
  - All other operations pass the current E unchanged.
- E flag update priority: `clr_e` > `ld_e` (take the ALU E output) > `cmp_e` (invert).
- Memory FSM, states IDLE, ACCESS:
  - IDLE → ACCESS when `mem_rd` or `mem_wr` is sampled. On that edge, latch `mem_addr` = AR and `mem_we` = `mem_wr`, and latch `mem_wdata` = bus (writes).
  - Non-memory fields of the same control word take effect on that same edge.
  - ACCESS: `mem_req` = 1. On `mem_ack` → IDLE; on a read, MBR captures `mem_rdata` on the same edge.
- `busy` = (state == ACCESS). While busy, all `ctrl` fields are treated as 0.
- `mem_rd` and `mem_wr` together: perform the write and set `err`.
- `inr` and `ld` on the same register is not an error; priority resolves it.
- `mem_ack` while IDLE is ignored.

## Timing
- Reset values: every register, E, MBR, `err`, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are 0; FSM in IDLE.
- Register transfers: 1 cycle. The result is visible on the `*_out` ports the cycle after the edge.
- Memory access:
  - Request cycle N: `mem_req` is high from N+1.
  - If `mem_ack` arrives in cycle M ≥ N+1, MBR is valid and `busy` is low from M+1.
  - Minimum access is 2 cycles.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable for the whole ACCESS state.
- `rst_n` low during ACCESS aborts the access immediately; `mem_req` drops asynchronously.

## Structure
- Package `bc_pkg`:
  - `ctrl_t` packed struct.
  - `bus_sel_e` and `alu_op_e` enums.
  - Default widths.
  - Memory FSM state enum.
- Sub-module `bc_reg`: parametrised `WIDTH` register with `clr`/`ld`/`inr` inputs and async active-low reset. Instantiated for AR, PC, DR, AC, IR (`inr` tied 0) and TR.

## Test plan
- Reset then PC `inr` ×3 → `pc_out` = 3. AR = 0xFFF with `inr` → `ar_out` = 0x000, with `ADDR_W` = 12.
- AC = 0xFFFF, DR = 0x0001, ADD with `ld_ac` + `ld_e` → AC = 0x0000, E = 1, `ac_zero` = 1. Then SHR → AC = 0x8000, E = 0.
- Read with AR = 0x123 and `mem_ack` 3 cycles after `mem_req` returning 0xBEEF:
  - `busy` high 3 cycles, `mem_addr` = 0x123 throughout.
  - A PC `inr` driven during `busy` is ignored.
  - `bus_sel` = 6 with `ld_dr` afterwards → DR = 0xBEEF.
- Write with AC = 0x5A5A on the bus and `mem_wr` → `mem_we` = 1, `mem_wdata` = 0x5A5A held until ack. `mem_rd` + `mem_wr` together → write performed, `err` = 1 stays set.
- `clr_ac`, `ld_ac` and `inr_ac` together with AC = 7 → AC = 0. `rst_n` pulsed mid-access → `mem_req` = 0, `busy` = 0, all outputs zero.
